// File: rtl/sim_controller.sv
// ---------------------------------------------------------------------------
// sim_controller
//
// Run controller for the pipelined core's simulation top. It holds the core
// in reset for a configurable number of cycles, then lets it run while it
// counts cycles and retired instructions. A run ends on one of three events:
//   - a write to TOHOST_ADDR (value 1 = PASS, anything else = FAIL),
//   - a retire-stall watchdog expiring (HANG),
//   - the global RUN-cycle budget running out (TIMEOUT).
// Once a run ends, the result is sticky until rst is sampled low again.
//
// Ports
//   clk           in   1      single clock, posedge
//   rst           in   1      synchronous, active-low reset
//   dbus_we       in   1      core data-bus write strobe
//   dbus_addr     in   XLEN   core data-bus write address
//   dbus_wdata    in   XLEN   core data-bus write data
//   retire        in   1      one instruction retired this cycle
//   core_rst      out  1      active-high reset to the core
//   running       out  1      controller is in RUN
//   done          out  1      sticky run-complete flag
//   result        out  3      0 none, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HANG
//   fail_code     out  XLEN-1 dbus_wdata[XLEN-1:1] captured on FAIL
//   cycle_count   out  CNT_W  RUN cycles elapsed
//   retire_count  out  CNT_W  instructions retired in RUN (saturating)
// ---------------------------------------------------------------------------
module sim_controller #(
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          CNT_W        = 32,
  parameter int unsigned          RESET_CYCLES = 2,
  parameter int unsigned          MAX_CYCLES   = 10000,
  parameter int unsigned          STALL_LIMIT  = 1024,
  parameter logic [XLEN-1:0]      TOHOST_ADDR  = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbus_we,
  input  logic [XLEN-1:0]   dbus_addr,
  input  logic [XLEN-1:0]   dbus_wdata,
  input  logic              retire,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic [2:0]        result,
  output logic [XLEN-2:0]   fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] RES_NONE    = 3'd0;
  localparam logic [2:0] RES_PASS    = 3'd1;
  localparam logic [2:0] RES_FAIL    = 3'd2;
  localparam logic [2:0] RES_TIMEOUT = 3'd3;
  localparam logic [2:0] RES_HANG    = 3'd4;

  // Hold counter only needs to reach RESET_CYCLES-1; +1 keeps the width
  // non-zero when RESET_CYCLES is 1.
  localparam int unsigned         HOLD_W     = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]    STALL_LAST =
    CNT_W'((STALL_LIMIT == 0) ? 0 : (STALL_LIMIT - 1));

  state_e              state_q,        state_d;
  logic [HOLD_W-1:0]   hold_cnt_q,     hold_cnt_d;
  logic                core_rst_q,     core_rst_d;
  logic                running_q,      running_d;
  logic                done_q,         done_d;
  logic [2:0]          result_q,       result_d;
  logic [XLEN-2:0]     fail_code_q,    fail_code_d;
  logic [CNT_W-1:0]    cycle_q,        cycle_d;
  logic [CNT_W-1:0]    retire_cnt_q,   retire_cnt_d;
  logic [CNT_W-1:0]    stall_q,        stall_d;

  logic                tohost_hit;
  logic                hang_hit;
  logic                timeout_hit;

  // Terminating-event detectors, all on the current cycle's inputs and the
  // pre-increment counter values.
  assign tohost_hit  = dbus_we && (dbus_addr == TOHOST_ADDR);
  assign timeout_hit = (cycle_q == CYCLE_LAST);

  // STALL_LIMIT of zero removes the watchdog entirely.
  generate
    if (STALL_LIMIT == 0) begin : g_no_watchdog
      assign hang_hit = 1'b0;
    end else begin : g_watchdog
      assign hang_hit = (stall_q == STALL_LAST) && !retire;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    core_rst_d   = core_rst_q;
    running_d    = running_q;
    done_d       = done_q;
    result_d     = result_q;
    fail_code_d  = fail_code_q;
    cycle_d      = cycle_q;
    retire_cnt_d = retire_cnt_q;
    stall_d      = stall_q;

    unique case (state_q)
      S_HOLD: begin
        // Tohost writes and retires are deliberately not looked at here.
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = S_RUN;
          core_rst_d = 1'b0;
          running_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Counters include the cycle on which the run terminates.
        cycle_d = cycle_q + 1'b1;
        if (retire && (retire_cnt_q != {CNT_W{1'b1}})) begin
          retire_cnt_d = retire_cnt_q + 1'b1;
        end
        if (retire) begin
          stall_d = '0;
        end else if (stall_q != {CNT_W{1'b1}}) begin
          stall_d = stall_q + 1'b1;
        end

        // Priority: tohost > hang > timeout.
        if (tohost_hit) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          if (dbus_wdata == XLEN'(1)) begin
            result_d = RES_PASS;
          end else begin
            result_d    = RES_FAIL;
            fail_code_d = dbus_wdata[XLEN-1:1];
          end
        end else if (hang_hit) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          result_d  = RES_HANG;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          running_d = 1'b0;
          done_d    = 1'b1;
          result_d  = RES_TIMEOUT;
        end
      end

      S_DONE: begin
        // Everything frozen until rst is sampled low.
      end

      default: begin
        // Unused encoding: restart the reset sequence.
        state_d    = S_HOLD;
        hold_cnt_d = '0;
        core_rst_d = 1'b1;
        running_d  = 1'b0;
        done_d     = 1'b0;
        result_d   = RES_NONE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      core_rst_q   <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= RES_NONE;
      fail_code_q  <= '0;
      cycle_q      <= '0;
      retire_cnt_q <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      core_rst_q   <= core_rst_d;
      running_q    <= running_d;
      done_q       <= done_d;
      result_q     <= result_d;
      fail_code_q  <= fail_code_d;
      cycle_q      <= cycle_d;
      retire_cnt_q <= retire_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign core_rst     = core_rst_q;
  assign running      = running_q;
  assign done         = done_q;
  assign result       = result_q;
  assign fail_code    = fail_code_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_cnt_q;

endmodule
